// File: rtl/fetch_issue_splitter.sv
// fetch_issue_splitter
// Consumes 2-wide fetch packets from the fetch queue dequeue port, holds one
// packet, and issues its valid instructions in program order to a 2-slot
// decoder that accepts 0, 1 or 2 instructions per cycle. Leftover
// instructions are compacted into slot 0. The packet's branch prediction is
// attached to its last valid instruction only.
//
// Ports:
//   clock, reset             clock, asynchronous active-high reset
//   io_i_flush               synchronous flush, drops the held packet
//   io_in_*                  fetch queue dequeue handshake and packet fields
//   io_out_*_0 / _1          issue slots (valid, pc, inst, prediction, ready)
//   io_perf_*                optional performance counters
//
// Optional feature: define FETCH_ISSUE_SPLITTER_PERF_EN to add the
// issue / stall / split performance counters.
module fetch_issue_splitter #(
    parameter int XLEN       = 64,
    parameter int INST_W     = 32,
    parameter int INST_BYTES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_i_flush,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic              io_in_bits_valids_0,
    input  logic              io_in_bits_valids_1,
    input  logic [XLEN-1:0]   io_in_bits_pc,
    input  logic [INST_W-1:0] io_in_bits_insts_0,
    input  logic [INST_W-1:0] io_in_bits_insts_1,
    input  logic              io_in_bits_branch_predict_pack_valid,
    input  logic              io_in_bits_branch_predict_pack_taken,
    input  logic [XLEN-1:0]   io_in_bits_branch_predict_pack_target,
    output logic              io_out_valid_0,
    output logic [XLEN-1:0]   io_out_pc_0,
    output logic [INST_W-1:0] io_out_inst_0,
    output logic              io_out_bp_valid_0,
    output logic              io_out_bp_taken_0,
    output logic [XLEN-1:0]   io_out_bp_target_0,
    input  logic              io_out_ready_0,
    output logic              io_out_valid_1,
    output logic [XLEN-1:0]   io_out_pc_1,
    output logic [INST_W-1:0] io_out_inst_1,
    output logic              io_out_bp_valid_1,
    output logic              io_out_bp_taken_1,
    output logic [XLEN-1:0]   io_out_bp_target_1,
    input  logic              io_out_ready_1
`ifdef FETCH_ISSUE_SPLITTER_PERF_EN
    ,
    output logic [31:0]       io_perf_issue_cnt,
    output logic [31:0]       io_perf_stall_cnt,
    output logic [31:0]       io_perf_split_cnt
`endif
);

    // The state value is the number of held instructions.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              bp_valid;
        logic              bp_taken;
        logic [XLEN-1:0]   bp_target;
    } entry_t;

    state_t state_r;
    state_t state_n_s;
    entry_t e0_r, e1_r;
    entry_t e0_n_s, e1_n_s;

    logic [1:0] cnt_s;
    logic       take0_s;
    logic [1:0] acc_s;
    logic [1:0] rem_s;
    logic       load_s;
    entry_t     slot0_s, slot1_s;
    entry_t     slot0_bp_s, slot1_bp_s;

    assign cnt_s   = state_r;
    // Acceptance is strictly in order: slot 1 only counts behind slot 0.
    assign take0_s = io_out_valid_0 & io_out_ready_0;
    assign acc_s   = {1'b0, take0_s} + {1'b0, take0_s & io_out_valid_1 & io_out_ready_1};
    assign rem_s   = cnt_s - acc_s;

    assign io_in_ready = (rem_s == 2'd0) & ~io_i_flush;
    assign load_s      = io_in_valid & io_in_ready;

    // Packet slots without prediction, and with the packet prediction attached.
    assign slot0_s    = '{pc: io_in_bits_pc, inst: io_in_bits_insts_0,
                          bp_valid: 1'b0, bp_taken: 1'b0, bp_target: '0};
    assign slot1_s    = '{pc: io_in_bits_pc + XLEN'(INST_BYTES), inst: io_in_bits_insts_1,
                          bp_valid: 1'b0, bp_taken: 1'b0, bp_target: '0};
    assign slot0_bp_s = '{pc: slot0_s.pc, inst: slot0_s.inst,
                          bp_valid: io_in_bits_branch_predict_pack_valid,
                          bp_taken: io_in_bits_branch_predict_pack_taken,
                          bp_target: io_in_bits_branch_predict_pack_target};
    assign slot1_bp_s = '{pc: slot1_s.pc, inst: slot1_s.inst,
                          bp_valid: io_in_bits_branch_predict_pack_valid,
                          bp_taken: io_in_bits_branch_predict_pack_taken,
                          bp_target: io_in_bits_branch_predict_pack_target};

    // Next-state and next-entry selection: flush, load, partial issue or hold.
    always_comb begin
        state_n_s = state_r;
        e0_n_s    = e0_r;
        e1_n_s    = e1_r;
        if (io_i_flush) begin
            state_n_s = ST_EMPTY;
        end else if (load_s) begin
            case ({io_in_bits_valids_0, io_in_bits_valids_1})
                2'b00: begin
                    state_n_s = ST_EMPTY;
                end
                2'b01: begin
                    e0_n_s    = slot1_bp_s;
                    state_n_s = ST_ONE;
                end
                2'b10: begin
                    e0_n_s    = slot0_bp_s;
                    state_n_s = ST_ONE;
                end
                2'b11: begin
                    e0_n_s    = slot0_s;
                    e1_n_s    = slot1_bp_s;
                    state_n_s = ST_TWO;
                end
                default: begin
                    state_n_s = ST_EMPTY;
                end
            endcase
        end else if (rem_s == 2'd0) begin
            state_n_s = ST_EMPTY;
        end else if ((state_r == ST_TWO) && (acc_s == 2'd1)) begin
            // Only the oldest left: the younger entry moves down to slot 0.
            e0_n_s    = e1_r;
            state_n_s = ST_ONE;
        end else begin
            state_n_s = state_r;
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Entry registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            e0_r <= '0;
            e1_r <= '0;
        end else begin
            e0_r <= e0_n_s;
            e1_r <= e1_n_s;
        end
    end

    assign io_out_valid_0     = (state_r != ST_EMPTY);
    assign io_out_valid_1     = (state_r == ST_TWO);
    assign io_out_pc_0        = e0_r.pc;
    assign io_out_inst_0      = e0_r.inst;
    assign io_out_bp_valid_0  = e0_r.bp_valid;
    assign io_out_bp_taken_0  = e0_r.bp_taken;
    assign io_out_bp_target_0 = e0_r.bp_target;
    assign io_out_pc_1        = e1_r.pc;
    assign io_out_inst_1      = e1_r.inst;
    assign io_out_bp_valid_1  = e1_r.bp_valid;
    assign io_out_bp_taken_1  = e1_r.bp_taken;
    assign io_out_bp_target_1 = e1_r.bp_target;

`ifdef FETCH_ISSUE_SPLITTER_PERF_EN
    logic [31:0] perf_issue_r, perf_stall_r, perf_split_r;

    // Performance counters; cleared only by reset, wrap naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_issue_r <= 32'd0;
            perf_stall_r <= 32'd0;
            perf_split_r <= 32'd0;
        end else begin
            perf_issue_r <= perf_issue_r + {30'd0, acc_s};
            perf_stall_r <= perf_stall_r + {31'd0, (cnt_s != 2'd0) && (acc_s == 2'd0)};
            perf_split_r <= perf_split_r + {31'd0, (state_r == ST_TWO) && (acc_s == 2'd1)};
        end
    end

    assign io_perf_issue_cnt = perf_issue_r;
    assign io_perf_stall_cnt = perf_stall_r;
    assign io_perf_split_cnt = perf_split_r;
`endif

endmodule

// File: tb/tb_fetch_issue_splitter.sv
// Self-checking bench for fetch_issue_splitter: a queue-based model of the
// held instructions is compared against the DUT every cycle, and directed
// scenarios pin hand-computed values.
module tb_fetch_issue_splitter;

    logic        clock, reset, io_i_flush;
    logic        io_in_valid, io_in_ready;
    logic        io_in_bits_valids_0, io_in_bits_valids_1;
    logic [63:0] io_in_bits_pc;
    logic [31:0] io_in_bits_insts_0, io_in_bits_insts_1;
    logic        bp_valid, bp_taken;
    logic [63:0] bp_target;
    logic        io_out_valid_0, io_out_bp_valid_0, io_out_bp_taken_0, io_out_ready_0;
    logic [63:0] io_out_pc_0, io_out_bp_target_0;
    logic [31:0] io_out_inst_0;
    logic        io_out_valid_1, io_out_bp_valid_1, io_out_bp_taken_1, io_out_ready_1;
    logic [63:0] io_out_pc_1, io_out_bp_target_1;
    logic [31:0] io_out_inst_1;
`ifdef FETCH_ISSUE_SPLITTER_PERF_EN
    logic [31:0] io_perf_issue_cnt, io_perf_stall_cnt, io_perf_split_cnt;
    logic [31:0] pi0, ps0;
    int m_issue, m_stall, m_split;
`endif

    int errors = 0;
    int checks = 0;

    fetch_issue_splitter #(.XLEN(64), .INST_W(32), .INST_BYTES(4)) dut (
        .clock(clock), .reset(reset), .io_i_flush(io_i_flush),
        .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
        .io_in_bits_valids_0(io_in_bits_valids_0), .io_in_bits_valids_1(io_in_bits_valids_1),
        .io_in_bits_pc(io_in_bits_pc),
        .io_in_bits_insts_0(io_in_bits_insts_0), .io_in_bits_insts_1(io_in_bits_insts_1),
        .io_in_bits_branch_predict_pack_valid(bp_valid),
        .io_in_bits_branch_predict_pack_taken(bp_taken),
        .io_in_bits_branch_predict_pack_target(bp_target),
        .io_out_valid_0(io_out_valid_0), .io_out_pc_0(io_out_pc_0), .io_out_inst_0(io_out_inst_0),
        .io_out_bp_valid_0(io_out_bp_valid_0), .io_out_bp_taken_0(io_out_bp_taken_0),
        .io_out_bp_target_0(io_out_bp_target_0), .io_out_ready_0(io_out_ready_0),
        .io_out_valid_1(io_out_valid_1), .io_out_pc_1(io_out_pc_1), .io_out_inst_1(io_out_inst_1),
        .io_out_bp_valid_1(io_out_bp_valid_1), .io_out_bp_taken_1(io_out_bp_taken_1),
        .io_out_bp_target_1(io_out_bp_target_1), .io_out_ready_1(io_out_ready_1)
`ifdef FETCH_ISSUE_SPLITTER_PERF_EN
        ,
        .io_perf_issue_cnt(io_perf_issue_cnt), .io_perf_stall_cnt(io_perf_stall_cnt),
        .io_perf_split_cnt(io_perf_split_cnt)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        bpv;
        logic        bpt;
        logic [63:0] tgt;
    } ent_t;

    ent_t mq[$];
    ent_t pk[$];
    int   m_n, m_a;

    // How many of n held instructions the decoder takes this cycle.
    function automatic int accepted(input int n, input logic r0, input logic r1);
        if (n >= 2 && r0 && r1) return 2;
        if (n >= 1 && r0) return 1;
        return 0;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete();
        end else begin
            m_n = mq.size();
            m_a = accepted(m_n, io_out_ready_0, io_out_ready_1);
`ifdef FETCH_ISSUE_SPLITTER_PERF_EN
            m_issue += m_a;
            if (m_n > 0 && m_a == 0) m_stall++;
            if (m_n == 2 && m_a == 1) m_split++;
`endif
            if (io_i_flush) begin
                mq.delete();
            end else begin
                for (int i = 0; i < m_a; i++) void'(mq.pop_front());
                if (io_in_valid && m_n == m_a) begin
                    pk.delete();
                    if (io_in_bits_valids_0)
                        pk.push_back('{io_in_bits_pc, io_in_bits_insts_0, 1'b0, 1'b0, 64'd0});
                    if (io_in_bits_valids_1)
                        pk.push_back('{io_in_bits_pc + 64'd4, io_in_bits_insts_1, 1'b0, 1'b0, 64'd0});
                    if (pk.size() > 0) begin
                        pk[pk.size()-1].bpv = bp_valid;
                        pk[pk.size()-1].bpt = bp_taken;
                        pk[pk.size()-1].tgt = bp_target;
                    end
                    foreach (pk[i]) mq.push_back(pk[i]);
                end
            end
        end
    end

    // Compare process: outputs against the model on every cycle out of reset.
    int c_n, c_a;
    always @(negedge clock) begin
        if (!reset) begin
            c_n = mq.size();
            c_a = accepted(c_n, io_out_ready_0, io_out_ready_1);
            chk("cmp_valid0", {63'd0, io_out_valid_0}, {63'd0, c_n >= 1});
            chk("cmp_valid1", {63'd0, io_out_valid_1}, {63'd0, c_n >= 2});
            chk("cmp_in_ready", {63'd0, io_in_ready}, {63'd0, (c_n == c_a) && !io_i_flush});
            if (c_n >= 1) begin
                chk("cmp_pc0", io_out_pc_0, mq[0].pc);
                chk("cmp_inst0", {32'd0, io_out_inst_0}, {32'd0, mq[0].inst});
                chk("cmp_bp0", {io_out_bp_valid_0, io_out_bp_taken_0, io_out_bp_target_0[61:0]},
                    {mq[0].bpv, mq[0].bpt, mq[0].tgt[61:0]});
            end
            if (c_n >= 2) begin
                chk("cmp_pc1", io_out_pc_1, mq[1].pc);
                chk("cmp_inst1", {32'd0, io_out_inst_1}, {32'd0, mq[1].inst});
                chk("cmp_bp1", {io_out_bp_valid_1, io_out_bp_taken_1, io_out_bp_target_1[61:0]},
                    {mq[1].bpv, mq[1].bpt, mq[1].tgt[61:0]});
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pkt(input logic v, input logic v0, input logic v1, input logic [63:0] pc,
                       input logic [31:0] i0, input logic [31:0] i1,
                       input logic bv, input logic bt, input logic [63:0] tg);
        io_in_valid         = v;
        io_in_bits_valids_0 = v0;
        io_in_bits_valids_1 = v1;
        io_in_bits_pc       = pc;
        io_in_bits_insts_0  = i0;
        io_in_bits_insts_1  = i1;
        bp_valid            = bv;
        bp_taken            = bt;
        bp_target           = tg;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef FETCH_ISSUE_SPLITTER_PERF_EN
        m_issue = 0; m_stall = 0; m_split = 0;
`endif
        reset = 1'b1;
        io_i_flush = 1'b0;
        io_out_ready_0 = 1'b0;
        io_out_ready_1 = 1'b0;
        pkt(1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 32'd0, 1'b0, 1'b0, 64'd0);
        #2;
        chk("rst_valid0", {63'd0, io_out_valid_0}, 64'd0);
        chk("rst_valid1", {63'd0, io_out_valid_1}, 64'd0);
        chk("rst_pc0", io_out_pc_0, 64'd0);
        chk("rst_tgt1", io_out_bp_target_1, 64'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_in_ready", {63'd0, io_in_ready}, 64'd1);

        // Back-to-back full issue.
        io_out_ready_0 = 1'b1;
        io_out_ready_1 = 1'b1;
        pkt(1'b1, 1'b1, 1'b1, 64'h8000_0000, 32'h13, 32'h93, 1'b0, 1'b0, 64'd0);
        step();
        chk("b2b_pc0", io_out_pc_0, 64'h8000_0000);
        chk("b2b_inst0", {32'd0, io_out_inst_0}, 64'h13);
        chk("b2b_pc1", io_out_pc_1, 64'h8000_0004);
        chk("b2b_inst1", {32'd0, io_out_inst_1}, 64'h93);
        pkt(1'b1, 1'b1, 1'b1, 64'h8000_0008, 32'h113, 32'h193, 1'b0, 1'b0, 64'd0);
        #1;
        chk("b2b_ready", {63'd0, io_in_ready}, 64'd1);
        step();
        chk("b2b_second_inst0", {32'd0, io_out_inst_0}, 64'h113);
        io_in_valid = 1'b0;
        step();
        chk("b2b_drained", {63'd0, io_out_valid_0}, 64'd0);

        // Partial issue: decoder takes one per cycle.
`ifdef FETCH_ISSUE_SPLITTER_PERF_EN
        pi0 = io_perf_issue_cnt;
        ps0 = io_perf_split_cnt;
`endif
        io_out_ready_1 = 1'b0;
        pkt(1'b1, 1'b1, 1'b1, 64'h1000, 32'hA0, 32'hB0, 1'b0, 1'b0, 64'd0);
        step();
        pkt(1'b1, 1'b1, 1'b1, 64'h2000, 32'hC0, 32'hD0, 1'b0, 1'b0, 64'd0);
        #1;
        chk("split_c1_inst0", {32'd0, io_out_inst_0}, 64'hA0);
        chk("split_c1_ready", {63'd0, io_in_ready}, 64'd0);
        step();
        chk("split_c2_inst0", {32'd0, io_out_inst_0}, 64'hB0);
        chk("split_c2_pc0", io_out_pc_0, 64'h1004);
        chk("split_c2_valid1", {63'd0, io_out_valid_1}, 64'd0);
        chk("split_c2_ready", {63'd0, io_in_ready}, 64'd1);
        step();
        chk("split_next_inst0", {32'd0, io_out_inst_0}, 64'hC0);
        io_in_valid = 1'b0;
        io_out_ready_1 = 1'b1;
        step();
`ifdef FETCH_ISSUE_SPLITTER_PERF_EN
        chk("perf_issue", {32'd0, io_perf_issue_cnt - pi0}, 64'd4);
        chk("perf_split", {32'd0, io_perf_split_cnt - ps0}, 64'd1);
`endif

        // Prediction placement.
        pkt(1'b1, 1'b0, 1'b1, 64'h100, 32'h111, 32'h222, 1'b1, 1'b1, 64'h200);
        step();
        io_in_valid = 1'b0;
        chk("bp01_valid1", {63'd0, io_out_valid_1}, 64'd0);
        chk("bp01_pc0", io_out_pc_0, 64'h104);
        chk("bp01_inst0", {32'd0, io_out_inst_0}, 64'h222);
        chk("bp01_tgt0", io_out_bp_target_0, 64'h200);
        chk("bp01_vt0", {62'd0, io_out_bp_valid_0, io_out_bp_taken_0}, 64'd3);
        pkt(1'b1, 1'b1, 1'b1, 64'h100, 32'h111, 32'h222, 1'b1, 1'b1, 64'h200);
        step();
        io_in_valid = 1'b0;
        chk("bp11_bpv0", {63'd0, io_out_bp_valid_0}, 64'd0);
        chk("bp11_tgt0", io_out_bp_target_0, 64'd0);
        chk("bp11_bpv1", {63'd0, io_out_bp_valid_1}, 64'd1);
        chk("bp11_tgt1", io_out_bp_target_1, 64'h200);
        step();

        // Empty packet is consumed and discarded.
        pkt(1'b1, 1'b0, 1'b0, 64'h500, 32'h1, 32'h2, 1'b0, 1'b0, 64'd0);
        #1;
        chk("v00_ready_before", {63'd0, io_in_ready}, 64'd1);
        step();
        chk("v00_valid0", {63'd0, io_out_valid_0}, 64'd0);
        chk("v00_ready_after", {63'd0, io_in_ready}, 64'd1);
        io_in_valid = 1'b0;
        step();

        // Flush while holding two with a stalled decoder.
        io_out_ready_0 = 1'b0;
        io_out_ready_1 = 1'b0;
        pkt(1'b1, 1'b1, 1'b1, 64'h2800, 32'h51, 32'h52, 1'b0, 1'b0, 64'd0);
        step();
        pkt(1'b1, 1'b1, 1'b1, 64'h3000, 32'h61, 32'h62, 1'b0, 1'b0, 64'd0);
        step();
        chk("fl_hold_valid1", {63'd0, io_out_valid_1}, 64'd1);
        io_i_flush = 1'b1;
        #1;
        chk("fl_ready", {63'd0, io_in_ready}, 64'd0);
        step();
        io_i_flush = 1'b0;
        chk("fl_valid0", {63'd0, io_out_valid_0}, 64'd0);
        chk("fl_valid1", {63'd0, io_out_valid_1}, 64'd0);
        io_out_ready_0 = 1'b1;
        io_out_ready_1 = 1'b1;
        step();
        io_in_valid = 1'b0;
        chk("fl_pending_pc0", io_out_pc_0, 64'h3000);
        step();

        // PC wrap of slot 1.
        pkt(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h71, 32'h72, 1'b0, 1'b0, 64'd0);
        step();
        io_in_valid = 1'b0;
        chk("wrap_pc1", io_out_pc_1, 64'd0);
        chk("wrap_pc0", io_out_pc_0, 64'hFFFF_FFFF_FFFF_FFFC);
        step();

        // Asynchronous reset mid-operation.
        io_out_ready_0 = 1'b0;
        pkt(1'b1, 1'b1, 1'b1, 64'h4000, 32'h81, 32'h82, 1'b1, 1'b0, 64'h44);
        step();
        io_in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("arst_valid0", {63'd0, io_out_valid_0}, 64'd0);
        chk("arst_pc0", io_out_pc_0, 64'd0);
        step();
        reset = 1'b0;
        #1;
        chk("arst_ready", {63'd0, io_in_ready}, 64'd1);
        step();
        step();

`ifdef FETCH_ISSUE_SPLITTER_PERF_EN
        chk("perf_model_issue", {32'd0, io_perf_issue_cnt}, 64'(m_issue));
        chk("perf_model_stall", {32'd0, io_perf_stall_cnt}, 64'(m_stall));
        chk("perf_model_split", {32'd0, io_perf_split_cnt}, 64'(m_split));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_issue_splitter.md
Name: fetch_issue_splitter

Overview:
- Consumer and scheduler for the fetch queue dequeue port. Holds one 2-wide fetch packet and issues its valid instructions in program order to a 2-slot decoder that can accept 0, 1 or 2 instructions per cycle.
- Compacts leftover instructions into slot 0 and attaches per-instruction PC and branch prediction.
- Backpressures the fetch queue until the held packet is fully issued.
- Handles pipeline flush.

Parameters:
- XLEN, 64, PC and branch-target width.
- INST_W, 32, instruction width.
- INST_BYTES, 4, PC stride between packet slot 0 and slot 1.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- io_i_flush  input  1  synchronous flush; drops held packet
- io_in_valid  input  1  fetch queue deq valid
- io_in_ready  output  1  fetch queue deq ready
- io_in_bits_valids_0 / io_in_bits_valids_1  input  1 each  packet slot valids
- io_in_bits_pc  input  XLEN  packet base PC (slot 0)
- io_in_bits_insts_0 / io_in_bits_insts_1  input  INST_W each  packet instructions
- io_in_bits_branch_predict_pack_valid / _taken  input  1 each  packet prediction
- io_in_bits_branch_predict_pack_target  input  XLEN  predicted target
- io_out_valid_k  output  1  issue slot k (k = 0, 1) valid
- io_out_pc_k  output  XLEN  issue slot k PC
- io_out_inst_k  output  INST_W  issue slot k instruction
- io_out_bp_valid_k / io_out_bp_taken_k  output  1 each  issue slot k prediction
- io_out_bp_target_k  output  XLEN  issue slot k predicted target
- io_out_ready_k  input  1  decoder accepts slot k; io_out_ready_1 is ignored unless io_out_ready_0 is 1

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Held state: cnt (0..2) plus registered entries E0 and E1 (pc, inst, bp fields). Entries are always compacted: E0 is the oldest.
- State machine, encoded by cnt:
  - EMPTY (cnt=0).
  - ONE (cnt=1), E0 only.
  - TWO (cnt=2), E0 then E1.
- Reset: cnt=0 and all entry registers 0, so every io_out_* is 0. io_in_ready = 1 once reset deasserts, unless io_i_flush is high.
- Outputs are driven purely from registers:
  - io_out_valid_0 = (cnt >= 1)
  - io_out_valid_1 = (cnt == 2)
  - Slot k fields = Ek
- Issued count: acc = v0 & r0 + (v0 & r0 & v1 & r1), where vk = io_out_valid_k and rk = io_out_ready_k. Acceptance is in order; slot 1 alone is never accepted.
- rem = cnt - acc.
- io_in_ready = (rem == 0) & ~io_i_flush. The queue is drained back-to-back with no bubble when the decoder consumes everything.
- Load on io_in_valid & io_in_ready: build a list of the valid slots in order.
  - Slot 0 PC = io_in_bits_pc.
  - Slot 1 PC = io_in_bits_pc + INST_BYTES, modulo 2^XLEN (wraps).
  - The packet's branch_predict_pack goes to the last valid instruction only. The other instruction gets bp_valid = 0, bp_taken = 0, bp_target = 0.
  - Next cnt = number of valid slots.
  - valids = 00: packet consumed and discarded, cnt stays 0.
  - valids = 01: inst_1 lands in E0 with PC base + INST_BYTES.
- Partial issue: in TWO with acc = 1, E1 shifts to E0 and cnt becomes 1. No load happens that cycle.
- Latency: a packet accepted in cycle N is visible on io_out in cycle N+1.
- Flush has priority over everything:
  - Next cnt = 0.
  - No load that cycle; io_in_ready is 0.
  - Decoder acceptance in the flush cycle is don't-care for the splitter.
  - Entry registers need not be cleared.
- Reset asserted mid-operation: immediate asynchronous return to EMPTY.

Optional Feature:
- Macro: FETCH_ISSUE_SPLITTER_PERF_EN.
- When defined, the block adds three outputs:
  - io_perf_issue_cnt (32 bits): instructions issued; increments by acc.
  - io_perf_stall_cnt (32 bits): cycles with cnt > 0 and acc == 0.
  - io_perf_split_cnt (32 bits): cycles where TWO issued exactly 1.
- All three counters reset to 0, wrap at 2^32, and clear on reset only (not on flush).
- When undefined: these ports and registers are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then push packet pc=0x8000_0000, valids=11, insts=0x13/0x93, with ready_0 = ready_1 = 1:
  - Next cycle: slot0 pc 0x8000_0000 inst 0x13, slot1 pc 0x8000_0004 inst 0x93.
  - io_in_ready stays 1, so the following packet issues back-to-back.
- Packet valids=11 with ready_0=1, ready_1=0:
  - Cycle 1: slot0 issues inst_0 and io_in_ready = 0.
  - Cycle 2: slot0 shows inst_1 at pc+4 with io_out_valid_1 = 0, and io_in_ready = 1.
- Packet valids=01, pc=0x100, bp valid/taken, target 0x200:
  - Only slot0 is valid, with pc 0x104 and bp_target 0x200.
  - Packet valids=11 with the same bp: bp appears on slot1 only; slot0 has bp_valid = 0.
- Packet valids=00 → no output valid, cnt stays 0, io_in_ready stays 1.
- Hold TWO with the decoder stalled, then assert io_i_flush with io_in_valid=1:
  - io_in_ready = 0 in the flush cycle.
  - Next cycle: all out valids are 0 and the pending packet is not consumed.
- pc=0xFFFF_FFFF_FFFF_FFFC, valids=11 → slot1 pc = 0x0 (wrap).
- With PERF_EN: 2 packets and 1 split → issue_cnt = 4, split_cnt = 1.
